// File: rtl/collision_probe_scheduler.sv
// collision_probe_scheduler
// Shares one background lookup port among the four character collision probes.
// Each game tick snapshots the character position, looks up down/right/left/up
// in that order, and publishes all four flags together on a single edge.
module collision_probe_scheduler #(
    parameter int         ROM_LAT  = 1,
    parameter logic [8:0] DOWN_DX  = 9'd4,
    parameter logic [8:0] DOWN_DY  = 9'd12,
    parameter logic [8:0] RIGHT_DX = 9'd11,
    parameter logic [8:0] RIGHT_DY = 9'd4,
    parameter logic [8:0] LEFT_DX  = 9'd508,
    parameter logic [8:0] LEFT_DY  = 9'd4,
    parameter logic [8:0] UP_DX    = 9'd4,
    parameter logic [8:0] UP_DY    = 9'd506
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [8:0] char_x,
    input  logic [8:0] char_y,
    output logic       rd_req,
    input  logic       rd_gnt,
    output logic [8:0] rd_x,
    output logic [8:0] rd_y,
    input  logic [2:0] rd_flag,
    output logic       busy,
    output logic       done,
    output logic [2:0] hit_down,
    output logic [2:0] hit_right,
    output logic [2:0] hit_left,
    output logic [2:0] hit_up,
    output logic [3:0] blocked,
    output logic       overrun
);

    localparam int CW = (ROM_LAT < 2) ? 1 : $clog2(ROM_LAT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    state_t        state;
    logic [1:0]    idx;
    logic [8:0]    snap_x;
    logic [8:0]    snap_y;
    logic [CW-1:0] wait_cnt;
    logic [2:0]    shadow [0:3];

    function automatic logic [8:0] off_x(input logic [1:0] i);
        case (i)
            2'd0:    off_x = DOWN_DX;
            2'd1:    off_x = RIGHT_DX;
            2'd2:    off_x = LEFT_DX;
            default: off_x = UP_DX;
        endcase
    endfunction

    function automatic logic [8:0] off_y(input logic [1:0] i);
        case (i)
            2'd0:    off_y = DOWN_DY;
            2'd1:    off_y = RIGHT_DY;
            2'd2:    off_y = LEFT_DY;
            default: off_y = UP_DY;
        endcase
    endfunction

    // Probe-round sequencer; the final probe's flag is published straight from rd_flag so all four land on the same edge as done.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= IDLE;
            idx      <= 2'd0;
            snap_x   <= 9'd0;
            snap_y   <= 9'd0;
            wait_cnt <= '0;
            rd_req   <= 1'b0;
            rd_x     <= 9'd0;
            rd_y     <= 9'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hit_down <= 3'd0;
            hit_right <= 3'd0;
            hit_left <= 3'd0;
            hit_up   <= 3'd0;
            blocked  <= 4'd0;
            overrun  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= 3'd0;
            end
        end else begin
            done <= 1'b0;
            if (start && (state != IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        snap_x <= char_x;
                        snap_y <= char_y;
                        idx    <= 2'd0;
                        rd_req <= 1'b1;
                        rd_x   <= char_x + DOWN_DX;
                        rd_y   <= char_y + DOWN_DY;
                        busy   <= 1'b1;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (rd_gnt) begin
                        rd_req   <= 1'b0;
                        wait_cnt <= ROM_LAT[CW-1:0];
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == CW'(1)) begin
                        shadow[idx] <= rd_flag;
                        if (idx != 2'd3) begin
                            idx    <= idx + 2'd1;
                            rd_req <= 1'b1;
                            rd_x   <= snap_x + off_x(idx + 2'd1);
                            rd_y   <= snap_y + off_y(idx + 2'd1);
                            state  <= REQ;
                        end else begin
                            hit_down  <= shadow[0];
                            hit_right <= shadow[1];
                            hit_left  <= shadow[2];
                            hit_up    <= rd_flag;
                            blocked   <= {|rd_flag, |shadow[2], |shadow[1], |shadow[0]};
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_collision_probe_scheduler.sv
// Directed bench for collision_probe_scheduler with a small address-keyed ROM model.
module tb_collision_probe_scheduler;

    logic       clock = 1'b0;
    logic       resetn;
    logic       start;
    logic [8:0] char_x;
    logic [8:0] char_y;
    logic       rd_req;
    logic       rd_gnt;
    logic [8:0] rd_x;
    logic [8:0] rd_y;
    logic [2:0] rd_flag;
    logic       busy;
    logic       done;
    logic [2:0] hit_down;
    logic [2:0] hit_right;
    logic [2:0] hit_left;
    logic [2:0] hit_up;
    logic [3:0] blocked;
    logic       overrun;

    int checks = 0;
    int failures = 0;

    logic [8:0] map_x [0:1];
    logic [8:0] map_y [0:1];
    logic [2:0] map_v [0:1];
    logic [2:0] rom_out = 3'b000;

    collision_probe_scheduler dut (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start),
        .char_x   (char_x),
        .char_y   (char_y),
        .rd_req   (rd_req),
        .rd_gnt   (rd_gnt),
        .rd_x     (rd_x),
        .rd_y     (rd_y),
        .rd_flag  (rd_flag),
        .busy     (busy),
        .done     (done),
        .hit_down (hit_down),
        .hit_right(hit_right),
        .hit_left (hit_left),
        .hit_up   (hit_up),
        .blocked  (blocked),
        .overrun  (overrun)
    );

    always #5 clock = ~clock;

    function automatic logic [2:0] rom_lookup(input logic [8:0] x, input logic [8:0] y);
        rom_lookup = 3'b000;
        for (int i = 0; i < 2; i++) begin
            if (map_v[i] != 3'b000 && map_x[i] == x && map_y[i] == y) begin
                rom_lookup = map_v[i];
            end
        end
    endfunction

    // ROM model: one-cycle latency; outside the valid cycle it drives 3'b111 as noise
    always @(posedge clock) begin
        if (rd_req && rd_gnt) begin
            rom_out <= rom_lookup(rd_x, rd_y);
        end else begin
            rom_out <= 3'b111;
        end
    end

    assign rd_flag = rom_out;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [8:0] x, input logic [8:0] y, input logic g);
        start  = s;
        char_x = x;
        char_y = y;
        rd_gnt = g;
    endtask

    task automatic setMap(input int i, input logic [8:0] x, input logic [8:0] y, input logic [2:0] v);
        map_x[i] = x;
        map_y[i] = y;
        map_v[i] = v;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [8:0] ex_x [0:3];
    logic [8:0] ex_y [0:3];

    initial begin
        ex_x[0] = 9'd39; ex_y[0] = 9'd217;
        ex_x[1] = 9'd46; ex_y[1] = 9'd209;
        ex_x[2] = 9'd31; ex_y[2] = 9'd209;
        ex_x[3] = 9'd39; ex_y[3] = 9'd199;
        setMap(0, 9'd0, 9'd0, 3'b000);
        setMap(1, 9'd0, 9'd0, 3'b000);

        // Reset state
        resetn = 1'b0;
        applyStimulus(1'b1, 9'd35, 9'd205, 1'b1);
        step();
        step();
        checkOutput("rst_rd_req", rd_req, 0);
        checkOutput("rst_rd_xy", {rd_x, rd_y}, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_hits", {hit_down, hit_right, hit_left, hit_up}, 0);
        checkOutput("rst_blocked", blocked, 0);
        checkOutput("rst_overrun", overrun, 0);
        resetn = 1'b1;
        applyStimulus(1'b0, 9'd35, 9'd205, 1'b1);
        step();
        checkOutput("idle_busy", busy, 0);

        // Tests 1+2: basic round, down probe hits 3'b010
        $display("[TB] round 1: char=(35,205), grant tied high");
        setMap(0, 9'd39, 9'd217, 3'b010);
        applyStimulus(1'b1, 9'd35, 9'd205, 1'b1);
        step();
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            checkOutput($sformatf("t1_rd_req_c%0d", c), rd_req, ((c % 2 == 1) && c <= 7) ? 1 : 0);
            checkOutput($sformatf("t1_done_c%0d", c), done, (c == 9) ? 1 : 0);
            checkOutput($sformatf("t1_busy_c%0d", c), busy, (c <= 9) ? 1 : 0);
            if ((c % 2 == 1) && c <= 7) begin
                checkOutput($sformatf("t1_addr_c%0d", c), {rd_x, rd_y}, {ex_x[c/2], ex_y[c/2]});
            end
            if (c == 9) begin
                checkOutput("t2_hit_down", hit_down, 3'b010);
                checkOutput("t2_other_hits", {hit_right, hit_left, hit_up}, 0);
                checkOutput("t2_blocked", blocked, 4'b0001);
            end
            if (c < 10) step();
        end
        checkOutput("t2_hold_hit_down", hit_down, 3'b010);

        // Test 3: grant withheld for 5 cycles at the right probe
        $display("[TB] round 2: grant stall on right probe");
        setMap(0, 9'd46, 9'd209, 3'b111);
        applyStimulus(1'b1, 9'd35, 9'd205, 1'b1);
        step();
        start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            rd_gnt = !(c >= 3 && c <= 7);
            checkOutput($sformatf("t3_rd_req_c%0d", c), rd_req,
                        (c == 1 || (c >= 3 && c <= 8) || c == 10 || c == 12) ? 1 : 0);
            checkOutput($sformatf("t3_done_c%0d", c), done, (c == 14) ? 1 : 0);
            if (c >= 3 && c <= 8) begin
                checkOutput($sformatf("t3_addr_hold_c%0d", c), {rd_x, rd_y}, {9'd46, 9'd209});
            end
            if (c == 13) begin
                checkOutput("t3_hit_down_held", hit_down, 3'b010);
            end
            if (c == 14) begin
                checkOutput("t3_hit_right", hit_right, 3'b111);
                checkOutput("t3_hit_down", hit_down, 3'b000);
                checkOutput("t3_blocked", blocked, 4'b0010);
            end
            step();
        end
        rd_gnt = 1'b1;
        checkOutput("t3_idle_busy", busy, 0);

        // Tests 4+6: wraparound, start while busy, inputs changed mid-round
        $display("[TB] round 3: char=(2,3) wrap, overrun, moving inputs");
        setMap(0, 9'd510, 9'd7, 3'b101);
        setMap(1, 9'd6, 9'd509, 3'b001);
        applyStimulus(1'b1, 9'd2, 9'd3, 1'b1);
        step();
        applyStimulus(1'b0, 9'd100, 9'd100, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            start = (c == 4);
            if (c == 4) checkOutput("t4_overrun_before", overrun, 0);
            if (c == 5) begin
                checkOutput("t4_overrun_set", overrun, 1);
                checkOutput("t4_left_addr", {rd_x, rd_y}, {9'd510, 9'd7});
            end
            if (c == 7) checkOutput("t4_up_addr", {rd_x, rd_y}, {9'd6, 9'd509});
            checkOutput($sformatf("t4_done_c%0d", c), done, (c == 9) ? 1 : 0);
            if (c == 9) begin
                checkOutput("t4_hits", {hit_down, hit_right, hit_left, hit_up},
                            {3'b000, 3'b000, 3'b101, 3'b001});
                checkOutput("t4_blocked", blocked, 4'b1100);
            end
            if (c == 10) begin
                checkOutput("t4_overrun_sticky", overrun, 1);
                checkOutput("t4_busy_end", busy, 0);
            end
            if (c < 10) step();
        end

        // Test 5: reset during the wait of probe 2, then a clean round
        $display("[TB] round 4: reset mid-round");
        setMap(0, 9'd39, 9'd217, 3'b010);
        setMap(1, 9'd0, 9'd0, 3'b000);
        applyStimulus(1'b1, 9'd35, 9'd205, 1'b1);
        step();
        start = 1'b0;
        for (int c = 1; c < 6; c++) step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        checkOutput("t5_rd_req", rd_req, 0);
        checkOutput("t5_rd_xy", {rd_x, rd_y}, 0);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_hits", {hit_down, hit_right, hit_left, hit_up}, 0);
        checkOutput("t5_blocked", blocked, 0);
        checkOutput("t5_overrun", overrun, 0);
        for (int c = 0; c < 4; c++) begin
            step();
            checkOutput($sformatf("t5_no_done_%0d", c), done, 0);
            checkOutput($sformatf("t5_idle_busy_%0d", c), busy, 0);
        end
        applyStimulus(1'b1, 9'd35, 9'd205, 1'b1);
        step();
        applyStimulus(1'b0, 9'd400, 9'd12, 1'b1);
        for (int c = 1; c <= 9; c++) begin
            if (c == 3) checkOutput("t5_right_addr", {rd_x, rd_y}, {9'd46, 9'd209});
            checkOutput($sformatf("t5_done_c%0d", c), done, (c == 9) ? 1 : 0);
            if (c < 9) step();
        end
        checkOutput("t5_hit_down", hit_down, 3'b010);
        checkOutput("t5_blocked_final", blocked, 4'b0001);
        checkOutput("t5_hit_left", hit_left, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
